// File: rtl/fixed_to_e4m3.sv
// Iterative signed fixed-point (Q format) to E4M3 converter with valid/ready handshakes.
// Define E4M3_NAN_ON_OVERFLOW_EN to emit NaN on overflow instead of saturating to +-448.
module fixed_to_e4m3 #(
  parameter int IN_WIDTH  = 20,
  parameter int FRAC_BITS = 10
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [IN_WIDTH-1:0] in_data,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [7:0]          y,
  output logic                is_output_valid,
  input  logic                out_ready
);

  localparam logic [5:0] EXP_INIT = 6'(IN_WIDTH - 1 - FRAC_BITS + 7);

`ifdef E4M3_NAN_ON_OVERFLOW_EN
  localparam logic [6:0] OVF_CODE = 7'h7F;
`else
  localparam logic [6:0] OVF_CODE = 7'h7E;
`endif

  typedef enum logic [1:0] {IDLE, NORMALIZE, ROUND, DONE} state_t;

  state_t              state;
  logic                sign;
  logic [IN_WIDTH-1:0] mag;
  logic [5:0]          exp_cnt;

  logic [IN_WIDTH-1:0] abs_in;
  logic                hid;
  logic [2:0]          man;
  logic                guard;
  logic                sticky;
  logic                inc;
  logic [4:0]          rsum;
  logic [6:0]          field;
  logic                ovf;

  assign in_ready = (state == IDLE);

  // The most negative input negates to itself, which reads correctly as 2^(IN_WIDTH-1) unsigned.
  assign abs_in = in_data[IN_WIDTH-1] ? (~in_data) + IN_WIDTH'(1) : in_data;

  always_comb begin
    hid    = mag[IN_WIDTH-1];
    man    = mag[IN_WIDTH-2:IN_WIDTH-4];
    guard  = mag[IN_WIDTH-5];
    sticky = |mag[IN_WIDTH-6:0];
    inc    = guard & (sticky | man[0]);
    rsum   = {1'b0, hid, man} + {4'b0000, inc};
    // A carry out of the hidden bit bumps the exponent; a subnormal rounding up to 1.000
    // lands in rsum[3] with exp_cnt already at 1, so it picks up field 1 naturally.
    if (rsum[4])
      field = {1'b0, exp_cnt} + 7'd1;
    else if (rsum[3])
      field = {1'b0, exp_cnt};
    else
      field = 7'd0;
    ovf = (field > 7'd15) || ((field == 7'd15) && (rsum[2:0] == 3'b111));
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state           <= IDLE;
      sign            <= 1'b0;
      mag             <= '0;
      exp_cnt         <= 6'd0;
      y               <= 8'h00;
      is_output_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            sign    <= in_data[IN_WIDTH-1];
            mag     <= abs_in;
            exp_cnt <= EXP_INIT;
            if (abs_in == '0) begin
              y               <= 8'h00;
              is_output_valid <= 1'b1;
              state           <= DONE;
            end else begin
              state <= NORMALIZE;
            end
          end
        end
        NORMALIZE: begin
          if (mag[IN_WIDTH-1] || (exp_cnt == 6'd1)) begin
            state <= ROUND;
          end else begin
            mag     <= mag << 1;
            exp_cnt <= exp_cnt - 6'd1;
          end
        end
        ROUND: begin
          if (ovf)
            y <= {sign, OVF_CODE};
          else
            y <= {sign, field[3:0], rsum[2:0]};
          is_output_valid <= 1'b1;
          state           <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            is_output_valid <= 1'b0;
            state           <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fixed_to_e4m3.sv
// Directed self-checking bench for fixed_to_e4m3 using hand-computed E4M3 encodings.
module tb_fixed_to_e4m3;

  logic        clock;
  logic        reset;
  logic [19:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  y;
  logic        is_output_valid;
  logic        out_ready;

  int checks = 0;
  int errors = 0;

`ifdef E4M3_NAN_ON_OVERFLOW_EN
  localparam logic [7:0] POS_OVF = 8'h7F;
  localparam logic [7:0] NEG_OVF = 8'hFF;
`else
  localparam logic [7:0] POS_OVF = 8'h7E;
  localparam logic [7:0] NEG_OVF = 8'hFE;
`endif

  fixed_to_e4m3 dut (
    .clock(clock),
    .reset(reset),
    .in_data(in_data),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .y(y),
    .is_output_valid(is_output_valid),
    .out_ready(out_ready)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Drives one operand, waits (bounded) for the result, then accepts it.
  task automatic run_conv(input logic [19:0] d, output logic [7:0] res, output int lat);
    @(negedge clock);
    in_data   = d;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    @(posedge clock);
    #1 in_valid = 1'b0;
    lat = 0;
    while (!is_output_valid && lat < 40) begin
      @(posedge clock);
      #1 lat++;
    end
    res = y;
    out_ready = 1'b1;
    @(posedge clock);
    #1 out_ready = 1'b0;
  endtask

  task automatic test_reset;
    in_data   = 20'h0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    reset     = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    checks++;
    if (y !== 8'h00) begin errors++; $display("[TB] FAIL reset_y: got %h want 00", y); end
    checks++;
    if (is_output_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b want 0", is_output_valid); end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_basic;
    int lat;
    int busy_bad;
    @(negedge clock);
    in_data   = 20'h00800;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(posedge clock);
    #1 in_valid = 1'b0;
    lat = 0;
    busy_bad = 0;
    while (!is_output_valid && lat < 40) begin
      if (in_ready !== 1'b0) busy_bad++;
      @(posedge clock);
      #1 lat++;
    end
    checks++;
    if (lat != 10) begin errors++; $display("[TB] FAIL basic_latency: got %0d want 10", lat); end
    checks++;
    if (busy_bad != 0) begin errors++; $display("[TB] FAIL basic_busy_ready: got %0d high cycles want 0", busy_bad); end
    checks++;
    if (y !== 8'h40) begin errors++; $display("[TB] FAIL basic_2p0: got %h want 40", y); end
    @(posedge clock);
    #1 out_ready = 1'b0;
    checks++;
    if (is_output_valid !== 1'b0) begin errors++; $display("[TB] FAIL basic_drain: got %b want 0", is_output_valid); end
  endtask

  task automatic test_values;
    logic [19:0] din  [9] = '{20'h00120, 20'hFF400, 20'h00440, 20'h004C0, 20'h00001,
                              20'h00003, 20'h70000, 20'h7D000, 20'h80000};
    logic [7:0]  want [9] = '{8'h29, 8'hC4, 8'h38, 8'h3A, 8'h00,
                              8'h02, 8'h7E, POS_OVF, NEG_OVF};
    logic [7:0] res;
    int lat;
    for (int i = 0; i < 9; i++) begin
      run_conv(din[i], res, lat);
      checks++;
      if (res !== want[i]) begin
        errors++;
        $display("[TB] FAIL value_%h: got %h want %h", din[i], res, want[i]);
      end
    end
    // 2^-10 needs the full 15 shifts before hitting exp==1.
    run_conv(20'h00001, res, lat);
    checks++;
    if (lat != 17) begin errors++; $display("[TB] FAIL worst_latency: got %0d want 17", lat); end
  endtask

  task automatic test_zero;
    logic [7:0] res;
    int lat;
    run_conv(20'h00000, res, lat);
    checks++;
    if (res !== 8'h00) begin errors++; $display("[TB] FAIL zero_value: got %h want 00", res); end
    checks++;
    if (lat != 0) begin errors++; $display("[TB] FAIL zero_latency: got %0d extra clocks want 0", lat); end
  endtask

  task automatic test_hold;
    int lat;
    @(negedge clock);
    in_data   = 20'h00440;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    @(posedge clock);
    #1 in_valid = 1'b0;
    lat = 0;
    while (!is_output_valid && lat < 40) begin
      @(posedge clock);
      #1 lat++;
    end
    in_data  = 20'h00800;
    in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clock);
      #1;
      checks++;
      if (y !== 8'h38 || is_output_valid !== 1'b1 || in_ready !== 1'b0) begin
        errors++;
        $display("[TB] FAIL hold_%0d: got y=%h v=%b r=%b want y=38 v=1 r=0", c, y, is_output_valid, in_ready);
      end
    end
    out_ready = 1'b1;
    @(posedge clock);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    checks++;
    if (is_output_valid !== 1'b0 || y !== 8'h38 || in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL hold_release: got y=%h v=%b r=%b want y=38 v=0 r=1", y, is_output_valid, in_ready);
    end
  endtask

  task automatic test_reset_midflight;
    logic [7:0] res;
    int lat;
    run_conv(20'hFF400, res, lat);
    @(negedge clock);
    in_data  = 20'h00800;
    in_valid = 1'b1;
    @(posedge clock);
    #1 in_valid = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    #1;
    checks++;
    if (y !== 8'h00 || is_output_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL midflight_reset: got y=%h v=%b want y=00 v=0", y, is_output_valid);
    end
    @(negedge clock);
    reset = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL midflight_ready: got %b want 1", in_ready); end
    run_conv(20'h00800, res, lat);
    checks++;
    if (res !== 8'h40) begin errors++; $display("[TB] FAIL midflight_next: got %h want 40", res); end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_values;
    test_zero;
    test_hold;
    test_reset_midflight;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
